// File: rtl/button_event_reg_if.sv
// button_event_reg_if: CPU-side read bus of the button event register.
interface button_event_reg_if #(
    parameter int NUM_BTN = 2,
    parameter int DATA_W  = 8
);
    logic              button_read;
    logic [DATA_W-1:0] button_op;
    logic              event_valid;
    logic              overflow;
    modport master (output button_read, input button_op, event_valid, overflow);
    modport slave  (input button_read, output button_op, event_valid, overflow);
endinterface

// File: rtl/button_event_reg.sv
// button_event_reg: synchronised, debounced multi-button event latch read and cleared by the CPU.
module button_event_reg #(
    parameter int NUM_BTN       = 2,
    parameter int DATA_W        = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_CYC  = 16,
    parameter int CONFLICT_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_BTN-1:0]   btn_in,
    button_event_reg_if.slave    bus
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic [NUM_BTN-1:0] deb, deb_q, pending, press;
    logic               read_q, rd_fire, conflict, ovf;
    logic [DATA_W-1:0]  op;
    genvar g;
    for (g = 0; g < NUM_BTN; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sq;
        logic [CW-1:0]          c;
        logic                   d, s;
        assign s      = sq[SYNC_STAGES-1];
        assign deb[g] = d;
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                sq <= '0;
                c  <= '0;
                d  <= 1'b0;
            end else begin
                sq <= {sq[SYNC_STAGES-2:0], btn_in[g]};
                if (s == d)
                    c <= '0;
                else if (c == CW'(DEBOUNCE_CYC - 1)) begin
                    d <= s;
                    c <= '0;
                end else
                    c <= c + CW'(1);
            end
    end
    assign press    = deb & ~deb_q;
    assign rd_fire  = bus.button_read & ~read_q;
    assign conflict = |(pending & (pending - NUM_BTN'(1)));
    // A press coinciding with the read strobe lands after the clear so it is never lost.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            deb_q   <= '0;
            read_q  <= 1'b0;
            pending <= '0;
            ovf     <= 1'b0;
            op      <= '0;
        end else begin
            deb_q   <= deb;
            read_q  <= bus.button_read;
            pending <= rd_fire ? press : (pending | press);
            ovf     <= rd_fire ? 1'b0 : (ovf | (|(press & pending)));
            if (rd_fire)
                op <= (CONFLICT_ZERO != 0 && conflict) ? '0 : DATA_W'(pending);
        end
    assign bus.button_op   = op;
    assign bus.event_valid = |pending;
    assign bus.overflow    = ovf;
endmodule

// File: tb/tb_button_event_reg.sv
// tb_button_event_reg: directed table plus corner sequences for both conflict policies.
module tb_button_event_reg;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       rd = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         lat;
    button_event_reg_if #(.NUM_BTN(2), .DATA_W(8)) bus_a ();
    button_event_reg_if #(.NUM_BTN(2), .DATA_W(8)) bus_b ();
    assign bus_a.button_read = rd;
    assign bus_b.button_read = rd;
    button_event_reg #(.CONFLICT_ZERO(1)) dut_a (.clk(clk), .reset(reset), .btn_in(btn), .bus(bus_a.slave));
    button_event_reg #(.CONFLICT_ZERO(0)) dut_b (.clk(clk), .reset(reset), .btn_in(btn), .bus(bus_b.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [1:0] btn;
        int         hold;
        bit         do_rd;
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic       ev;
        logic       ovf;
    } vec_t;
    vec_t v[15];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic rd_pulse();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
    endtask
    task automatic hold(input logic [1:0] b, input int n);
        btn = b;
        repeat (n) tick();
    endtask
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        v[0]  = '{2'b00,  5, 1, 8'h00, 8'h00, 0, 0};
        v[1]  = '{2'b01, 25, 0, 8'h00, 8'h00, 1, 0};
        v[2]  = '{2'b01,  2, 1, 8'h01, 8'h01, 0, 0};
        v[3]  = '{2'b00, 25, 0, 8'h01, 8'h01, 0, 0};
        v[4]  = '{2'b10, 25, 0, 8'h01, 8'h01, 1, 0};
        v[5]  = '{2'b10,  2, 1, 8'h02, 8'h02, 0, 0};
        v[6]  = '{2'b00, 25, 0, 8'h02, 8'h02, 0, 0};
        v[7]  = '{2'b11, 25, 0, 8'h02, 8'h02, 1, 0};
        v[8]  = '{2'b11,  2, 1, 8'h00, 8'h03, 0, 0};
        v[9]  = '{2'b00, 25, 0, 8'h00, 8'h03, 0, 0};
        v[10] = '{2'b01, 25, 0, 8'h00, 8'h03, 1, 0};
        v[11] = '{2'b00, 25, 0, 8'h00, 8'h03, 1, 0};
        v[12] = '{2'b01, 25, 0, 8'h00, 8'h03, 1, 1};
        v[13] = '{2'b01,  2, 1, 8'h01, 8'h01, 0, 0};
        v[14] = '{2'b01,  3, 1, 8'h00, 8'h00, 0, 0};
        #2;
        chk("reset op", bus_a.button_op, 8'h00);
        chk("reset ev", 8'(bus_a.event_valid), 8'h0);
        chk("reset ovf", 8'(bus_a.overflow), 8'h0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            hold(v[i].btn, v[i].hold);
            if (v[i].do_rd) rd_pulse();
            chk($sformatf("row%0d op_a", i), bus_a.button_op, v[i].op_a);
            chk($sformatf("row%0d op_b", i), bus_b.button_op, v[i].op_b);
            chk($sformatf("row%0d ev", i), 8'(bus_a.event_valid), 8'(v[i].ev));
            chk($sformatf("row%0d ovf", i), 8'(bus_a.overflow), 8'(v[i].ovf));
        end
        // bouncing input: only the final stable level counts
        hold(2'b00, 25);
        for (int k = 0; k < 12; k++) hold({1'b0, k % 2 == 0}, 3);
        chk("bounce no event", 8'(bus_a.event_valid), 8'h0);
        btn = 2'b01;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            tick();
            if (bus_a.event_valid) lat = n;
        end
        chk("bounce latency", 8'(lat), 8'd19);
        rd_pulse();
        chk("bounce read", bus_a.button_op, 8'h01);
        chk("bounce ev after read", 8'(bus_a.event_valid), 8'h0);
        // ch1 press lands in the read-strobe cycle while ch0 is pending
        hold(2'b00, 25);
        hold(2'b01, 25);
        hold(2'b11, 18);
        rd_pulse();
        chk("race op_a", bus_a.button_op, 8'h01);
        chk("race op_b", bus_b.button_op, 8'h01);
        chk("race ev", 8'(bus_a.event_valid), 8'h1);
        rd_pulse();
        chk("race next op_a", bus_a.button_op, 8'h02);
        chk("race next ev", 8'(bus_a.event_valid), 8'h0);
        // overflow-worthy press in the read-strobe cycle survives without flagging
        hold(2'b10, 25);
        hold(2'b11, 25);
        hold(2'b10, 25);
        hold(2'b11, 18);
        rd_pulse();
        chk("ovf race op", bus_a.button_op, 8'h01);
        chk("ovf race ev", 8'(bus_a.event_valid), 8'h1);
        chk("ovf race ovf", 8'(bus_a.overflow), 8'h0);
        rd_pulse();
        chk("ovf race next op", bus_a.button_op, 8'h01);
        chk("ovf race next ev", 8'(bus_a.event_valid), 8'h0);
        // read level held high yields one read only
        hold(2'b01, 25);
        hold(2'b00, 25);
        hold(2'b01, 25);
        btn = 2'b11;
        rd = 1'b1;
        tick();
        chk("held first op", bus_a.button_op, 8'h01);
        chk("held first ev", 8'(bus_a.event_valid), 8'h0);
        repeat (24) tick();
        chk("held press ev", 8'(bus_a.event_valid), 8'h1);
        chk("held op stable", bus_a.button_op, 8'h01);
        rd = 1'b0;
        tick();
        chk("held release ev", 8'(bus_a.event_valid), 8'h1);
        rd_pulse();
        chk("held second op", bus_a.button_op, 8'h02);
        chk("held second ev", 8'(bus_a.event_valid), 8'h0);
        // async reset discards pending, overflow and read data
        hold(2'b10, 25);
        hold(2'b11, 25);
        chk("pre-reset ev", 8'(bus_a.event_valid), 8'h1);
        hold(2'b10, 25);
        hold(2'b11, 25);
        chk("pre-reset ovf", 8'(bus_a.overflow), 8'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset op_a", bus_a.button_op, 8'h00);
        chk("async reset op_b", bus_b.button_op, 8'h00);
        chk("async reset ev", 8'(bus_a.event_valid), 8'h0);
        chk("async reset ovf", 8'(bus_a.overflow), 8'h0);
        btn = 2'b00;
        repeat (3) tick();
        reset = 1'b1;
        repeat (25) tick();
        chk("post-reset ev", 8'(bus_a.event_valid), 8'h0);
        rd_pulse();
        chk("post-reset read", bus_a.button_op, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
